bresenham_line: RTL

Single-line pixel generator that walks the integer Bresenham path between two 2D endpoints and emits one pixel per accepted handshake. It sits directly downstream of the triangle rasterizer controller, which supplies one edge's endpoints and a start pulse and waits for `done`. It sits upstream of the framebuffer write stage, which consumes pixels through a valid/ready interface and may stall.

---
 rtl/bresenham_line_if.sv | 28 ++
 rtl/bresenham_line.sv | 100 ++++++++++
 2 files changed

// File: rtl/bresenham_line_if.sv
// rtl/bresenham_line_if.sv - line request and pixel stream bundle for bresenham_line
interface bresenham_line_if #(
    parameter int COORD_W = 10
);
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    logic   start;
    point_t p;
    point_t q;
    point_t pixel;
    logic   pixel_valid;
    logic   pixel_ready;
    logic   busy;
    logic   done;

    modport master (
        output start, p, q, pixel_ready,
        input  pixel, pixel_valid, busy, done
    );

    modport slave (
        input  start, p, q, pixel_ready,
        output pixel, pixel_valid, busy, done
    );
endinterface

// File: rtl/bresenham_line.sv
// rtl/bresenham_line.sv - Bresenham line walker emitting one pixel per accepted handshake
module bresenham_line #(
    parameter int COORD_W = 10
) (
    input logic           clk,
    input logic           n_rst,
    bresenham_line_if.slave bus
);
    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, PLOT, DONE} state_t;

    state_t               state;
    logic [COORD_W-1:0]   cx, cy, ex, ey;
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;
    logic                 pixel_valid_r, busy_r, done_r;

    logic [EW-1:0]        abs_dx, abs_dy;
    logic signed [EW:0]   e2, dx_ext, dy_ext;
    logic                 step_x, step_y, at_end;
    logic signed [EW-1:0] err_next;

    assign abs_dx = (cx < ex) ? {2'b00, ex - cx} : {2'b00, cx - ex};
    assign abs_dy = (cy < ey) ? {2'b00, ey - cy} : {2'b00, cy - ey};

    // Both step decisions use the pre-update error so diagonal moves happen in one cycle.
    assign e2       = {err, 1'b0};
    assign dx_ext   = {dx[EW-1], dx};
    assign dy_ext   = {dy[EW-1], dy};
    assign step_x   = (e2 >= dy_ext);
    assign step_y   = (e2 <= dx_ext);
    assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    assign at_end   = (cx == ex) && (cy == ey);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cx            <= '0;
            cy            <= '0;
            ex            <= '0;
            ey            <= '0;
            dx            <= '0;
            dy            <= '0;
            err           <= '0;
            sx_neg        <= 1'b0;
            sy_neg        <= 1'b0;
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cx     <= bus.p.x;
                        cy     <= bus.p.y;
                        ex     <= bus.q.x;
                        ey     <= bus.q.y;
                        busy_r <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    dx            <= $signed(abs_dx);
                    dy            <= -$signed(abs_dy);
                    err           <= $signed(abs_dx) - $signed(abs_dy);
                    sx_neg        <= !(cx < ex);
                    sy_neg        <= !(cy < ey);
                    pixel_valid_r <= 1'b1;
                    state         <= PLOT;
                end
                PLOT: begin
                    if (bus.pixel_ready) begin
                        if (at_end) begin
                            pixel_valid_r <= 1'b0;
                            done_r        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            err <= err_next;
                            if (step_x) cx <= sx_neg ? cx - ONE : cx + ONE;
                            if (step_y) cy <= sy_neg ? cy - ONE : cy + ONE;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pixel       = {cx, cy};
    assign bus.pixel_valid = pixel_valid_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
endmodule
